// File: rtl/ext_ram_pkg.sv
// Shared types and limits for the external-RAM bus master.
// Build option: EXT_RAM_TURNAROUND_EN adds the post-read bus-release state.
package ext_ram_pkg;

  localparam int WAIT_W     = 4;
  localparam int ADDR_W_MIN = 1;
  localparam int ADDR_W_MAX = 16;
  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 64;
  localparam int WAIT_MAX   = (1 << WAIT_W) - 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
`ifdef EXT_RAM_TURNAROUND_EN
    ,
    TURN
`endif
  } state_e;

endpackage

// File: rtl/ext_ram_port_if.sv
// Core request/response channel plus the split external SRAM pad signals.
// master = the RAM port itself; slave = the core and pad shell around it.
interface ext_ram_port_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_data_o;
  logic              ram_data_oe_o;
  logic [DATA_W-1:0] ram_data_i;
  logic              ram_rw_en_o;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, ram_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
           ram_addr_o, ram_data_o, ram_data_oe_o, ram_rw_en_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, ram_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
           ram_addr_o, ram_data_o, ram_data_oe_o, ram_rw_en_o
  );
endinterface

// File: rtl/ext_ram_wait_ctr.sv
// Loadable wait-state down-counter; load has priority, stops at zero; zero flag is combinational.
// No backpressure: counts whenever enabled.
module ext_ram_wait_ctr
  import ext_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [WAIT_W-1:0] load_val,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ext_ram_port.sv
// External SRAM master: setup, WAIT_CYCLES+1 strobe cycles, hold; response in cycle 3+WAIT_CYCLES.
// One request outstanding, ready only in IDLE; EXT_RAM_TURNAROUND_EN adds a release cycle after reads.
module ext_ram_port
  import ext_ram_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           fpgaGlobalClock,
  input  logic           reset_i,
  ext_ram_port_if.master bus
);

  if (ADDR_W < ADDR_W_MIN || ADDR_W > ADDR_W_MAX) begin : g_bad_addr_w
    $error("ext_ram_port: ADDR_W out of range");
  end
  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("ext_ram_port: DATA_W out of range");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("ext_ram_port: WAIT_CYCLES out of range");
  end

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic              accept;
  logic              ctr_load, ctr_en, ctr_zero;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge fpgaGlobalClock or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        ctr_load = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (ctr_zero) begin
          state_d = HOLD;
        end else begin
          ctr_en = 1'b1;
        end
      end
      HOLD: begin
`ifdef EXT_RAM_TURNAROUND_EN
        state_d = we_q ? IDLE : TURN;
`else
        state_d = IDLE;
`endif
      end
`ifdef EXT_RAM_TURNAROUND_EN
      TURN: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  ext_ram_wait_ctr u_wait_ctr (
    .clk      (fpgaGlobalClock),
    .rst      (reset_i),
    .load     (ctr_load),
    .en       (ctr_en),
    .load_val (WAIT_LOAD),
    .zero     (ctr_zero)
  );

  // Address only moves on acceptance, so it is stable around every strobe.
  always_ff @(posedge fpgaGlobalClock or posedge reset_i) begin
    if (reset_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we_i;
      addr_q  <= bus.req_addr_i;
      wdata_q <= bus.req_wdata_i;
    end
  end

  always_ff @(posedge fpgaGlobalClock or posedge reset_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (state_q == ACCESS && ctr_zero && !we_q) begin
      rdata_q <= bus.ram_data_i;
    end
  end

  // Pin controls decode straight from reset-cleared flops so a reset drops them immediately.
  assign bus.req_ready_o   = (state_q == IDLE);
  assign bus.rsp_valid_o   = (state_q == HOLD);
  assign bus.rsp_rdata_o   = rdata_q;
  assign bus.ram_addr_o    = addr_q;
  assign bus.ram_data_o    = wdata_q;
  assign bus.ram_rw_en_o   = (state_q == ACCESS) && we_q;
  assign bus.ram_data_oe_o = we_q && ((state_q == SETUP) || (state_q == ACCESS) || (state_q == HOLD));

endmodule

// File: tb/tb_ext_ram_port.sv
// Directed bench for ext_ram_port: main instance WAIT_CYCLES=1, plus 0 and 15 instances for strobe/latency limits.
module tb_ext_ram_port;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ext_ram_port_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  ext_ram_port_if #(.ADDR_W(5), .DATA_W(32)) bus0 ();
  ext_ram_port_if #(.ADDR_W(5), .DATA_W(32)) bus15 ();

  ext_ram_port #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(1)) u_dut (
    .fpgaGlobalClock (clk), .reset_i (reset_i), .bus (bus));
  ext_ram_port #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
    .fpgaGlobalClock (clk), .reset_i (reset_i), .bus (bus0));
  ext_ram_port #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(15)) u_dut_w15 (
    .fpgaGlobalClock (clk), .reset_i (reset_i), .bus (bus15));

  // SRAM model for the main instance; writes land mid-cycle while the strobe is high
  logic [31:0] mem [32];
  always @(negedge clk) if (bus.ram_rw_en_o) mem[bus.ram_addr_o] <= bus.ram_data_o;
  assign bus.ram_data_i   = mem[bus.ram_addr_o];
  assign bus0.ram_data_i  = 32'h0;
  assign bus15.ram_data_i = 32'h0;

  int rw_cnt = 0, oe_cnt = 0, rsp_cnt = 0, rw0_cnt = 0, rw15_cnt = 0;
  always @(negedge clk) begin
    rw_cnt   <= rw_cnt + int'(bus.ram_rw_en_o);
    oe_cnt   <= oe_cnt + int'(bus.ram_data_oe_o);
    rsp_cnt  <= rsp_cnt + int'(bus.rsp_valid_o);
    rw0_cnt  <= rw0_cnt + int'(bus0.ram_rw_en_o);
    rw15_cnt <= rw15_cnt + int'(bus15.ram_rw_en_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request when ready, returns edges from acceptance (inclusive) to the rsp_valid sample.
  task automatic xfer(input logic we, input logic [4:0] a, input logic [31:0] d, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready_o && n < 20) begin step(); n++; end
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_addr_i = a; bus.req_wdata_i = d;
    step();
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (!bus.rsp_valid_o && lat < 40) begin step(); lat++; end
  endtask

  initial begin
    int lat, l0, l15, gap, n, s_rw, s_oe, s_rsp, s_rw0, s_rw15;
    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus0.req_valid_i = 0; bus0.req_we_i = 0; bus0.req_addr_i = '0; bus0.req_wdata_i = '0;
    bus15.req_valid_i = 0; bus15.req_we_i = 0; bus15.req_addr_i = '0; bus15.req_wdata_i = '0;

    // reset values, checked before any clock edge
    #1 reset_i = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'h1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    chk("rst_rdata", 64'(bus.rsp_rdata_o), 64'h0);
    chk("rst_addr", 64'(bus.ram_addr_o), 64'h0);
    chk("rst_data", 64'(bus.ram_data_o), 64'h0);
    chk("rst_oe", 64'(bus.ram_data_oe_o), 64'h0);
    chk("rst_rw_en", 64'(bus.ram_rw_en_o), 64'h0);
    step(); step();
    reset_i = 1'b0;
    step();

    // single write
    s_rw = rw_cnt; s_oe = oe_cnt; s_rsp = rsp_cnt;
    xfer(1'b1, 5'h03, 32'hDEADBEEF, lat);
    chk("wr_latency", 64'(lat), 64'd4);
    step();
    chk("wr_strobe_cycles", 64'(rw_cnt - s_rw), 64'd2);
    chk("wr_oe_cycles", 64'(oe_cnt - s_oe), 64'd4);
    chk("wr_rsp_pulses", 64'(rsp_cnt - s_rsp), 64'd1);
    chk("wr_mem", 64'(mem[3]), 64'hDEADBEEF);
    chk("wr_ready_after", 64'(bus.req_ready_o), 64'h1);
    chk("wr_addr_held", 64'(bus.ram_addr_o), 64'h03);

    // single read of the same word
    s_oe = oe_cnt;
    xfer(1'b0, 5'h03, 32'h0, lat);
    chk("rd_latency", 64'(lat), 64'd4);
    chk("rd_rdata", 64'(bus.rsp_rdata_o), 64'hDEADBEEF);
    step();
    chk("rd_oe_cycles", 64'(oe_cnt - s_oe), 64'd0);

    // write then read with valid held, full-width address and data
    n = 0;
    while (!bus.req_ready_o && n < 20) begin step(); n++; end
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 5'h1F; bus.req_wdata_i = 32'hFFFFFFFF;
    step();
    bus.req_we_i = 1'b0; bus.req_wdata_i = 32'h0;
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin step(); n++; end
    chk("b2b_hold_addr", 64'(bus.ram_addr_o), 64'h1F);
    chk("b2b_hold_data", 64'(bus.ram_data_o), 64'hFFFFFFFF);
    chk("b2b_hold_oe", 64'(bus.ram_data_oe_o), 64'h1);
    step();
    chk("b2b_idle_ready", 64'(bus.req_ready_o), 64'h1);
    step();
    chk("b2b_accepted", 64'(bus.req_ready_o), 64'h0);
    chk("b2b_rd_oe", 64'(bus.ram_data_oe_o), 64'h0);
    bus.req_valid_i = 1'b0;
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin step(); n++; end
    chk("b2b_rd_rdata", 64'(bus.rsp_rdata_o), 64'hFFFFFFFF);
    step();

    // read then write with valid held: edges from read HOLD to write SETUP
    n = 0;
    while (!bus.req_ready_o && n < 20) begin step(); n++; end
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 5'h03;
    step();
    bus.req_we_i = 1'b1; bus.req_addr_i = 5'h04; bus.req_wdata_i = 32'h0A5A5A5A;
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin step(); n++; end
    gap = 0;
    while (!bus.ram_data_oe_o && gap < 20) begin step(); gap++; end
    bus.req_valid_i = 1'b0;
`ifdef EXT_RAM_TURNAROUND_EN
    chk("rw_gap", 64'(gap), 64'd3);
`else
    chk("rw_gap", 64'(gap), 64'd2);
`endif
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin step(); n++; end
    step();
    chk("rw_mem", 64'(mem[4]), 64'h0A5A5A5A);

    // wait-state limits
    s_rw0 = rw0_cnt; s_rw15 = rw15_cnt;
    bus0.req_valid_i = 1'b1; bus0.req_we_i = 1'b1; bus0.req_addr_i = 5'h02; bus0.req_wdata_i = 32'h1;
    bus15.req_valid_i = 1'b1; bus15.req_we_i = 1'b1; bus15.req_addr_i = 5'h02; bus15.req_wdata_i = 32'h1;
    step();
    bus0.req_valid_i = 1'b0; bus15.req_valid_i = 1'b0;
    l0 = 0; l15 = 0;
    for (int i = 2; i <= 25; i++) begin
      step();
      if (bus0.rsp_valid_o && l0 == 0) l0 = i;
      if (bus15.rsp_valid_o && l15 == 0) l15 = i;
    end
    chk("w0_latency", 64'(l0), 64'd3);
    chk("w15_latency", 64'(l15), 64'd18);
    chk("w0_strobe_cycles", 64'(rw0_cnt - s_rw0), 64'd1);
    chk("w15_strobe_cycles", 64'(rw15_cnt - s_rw15), 64'd16);

    // reset during write ACCESS
    n = 0;
    while (!bus.req_ready_o && n < 20) begin step(); n++; end
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 5'h07; bus.req_wdata_i = 32'h12345678;
    step();
    bus.req_valid_i = 1'b0;
    step();
    chk("abort_pre_rw", 64'(bus.ram_rw_en_o), 64'h1);
    chk("abort_pre_oe", 64'(bus.ram_data_oe_o), 64'h1);
    s_rsp = rsp_cnt;
    #2 reset_i = 1'b1;
    #1;
    chk("abort_rw_async", 64'(bus.ram_rw_en_o), 64'h0);
    chk("abort_oe_async", 64'(bus.ram_data_oe_o), 64'h0);
    step();
    reset_i = 1'b0;
    step();
    chk("abort_ready", 64'(bus.req_ready_o), 64'h1);
    step(); step(); step(); step();
    chk("abort_no_rsp", 64'(rsp_cnt - s_rsp), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ext_ram_port.md
# ext_ram_port

Parametrised external-RAM bus master sitting between the Baby core's memory request interface and the top-level pad shell. Converts a single-outstanding valid/ready request into a timed external SRAM cycle with setup, programmable wait states and hold. The address and data widths are generic. The split data-out/data-in/output-enable pads are resolved to the bidirectional pins in the shell. It replaces the fixed 5-bit-address, 32-bit, zero-wait direct drive of the store.

## Interface
Parameters:
- ADDR_W, 5: external address width (1..16)
- DATA_W, 32: word width (8..64)
- WAIT_CYCLES, 1: extra strobe cycles per access (0..15)

Ports:
- fpgaGlobalClock  in  1  sole clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  port can accept a request
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_W  word address
- req_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  one-cycle completion pulse, for both reads and writes
- rsp_rdata_o  out  DATA_W  read data; held until the next read completes
- ram_addr_o  out  ADDR_W  external address
- ram_data_o  out  DATA_W  external write data
- ram_data_oe_o  out  1  drive enable for the data pins
- ram_data_i  in  DATA_W  external read data
- ram_rw_en_o  out  1  write strobe, active high

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD, TURN. TURN exists only with the macro.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o: latch we, addr and wdata; drive ram_addr_o; go to SETUP.
- SETUP (1 cycle):
  - Address is stable and ram_rw_en_o = 0.
  - On a write: ram_data_oe_o = 1 and ram_data_o = latched wdata.
  - Load the wait counter with WAIT_CYCLES; go to ACCESS.
- ACCESS (WAIT_CYCLES+1 cycles):
  - ram_rw_en_o = latched we.
  - Counter decrements each cycle; leave ACCESS when it reaches 0.
  - On a read: sample ram_data_i into rsp_rdata_o on the final ACCESS edge.
  - Go to HOLD.
- HOLD (1 cycle):
  - ram_rw_en_o = 0; address held; ram_data_oe_o stays 1 on writes to give data hold time.
  - rsp_valid_o = 1.
  - Next state is IDLE, or TURN after a read when the macro is enabled.
- ram_data_oe_o is 0 in every state except SETUP, ACCESS and HOLD of a write.
- req_* inputs are ignored outside IDLE.
- Only one request is outstanding at a time; there is no queueing.
- ram_addr_o holds its last value while in IDLE.
- Request inputs are not required to stay stable after acceptance.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE
  - req_ready_o = 1
  - rsp_valid_o = 0
  - rsp_rdata_o = 0
  - ram_addr_o = 0
  - ram_data_o = 0
  - ram_data_oe_o = 0
  - ram_rw_en_o = 0
- Reset asserted mid-access aborts the cycle. Strobe and drive enable drop without waiting for a clock edge, and no rsp_valid_o is issued.
- Latency: request accepted at edge 0 → rsp_valid_o high in cycle 3+WAIT_CYCLES.
- Throughput without the macro: one access every 4+WAIT_CYCLES cycles. With the macro, reads take one cycle more.
- req_ready_o is high in the same cycle the FSM re-enters IDLE.
- A request presented in that cycle is accepted, so back-to-back requests leave exactly one IDLE cycle between them.
- The write strobe never overlaps an address change: the address changes only on the IDLE→SETUP edge.

## Configuration
- EXT_RAM_TURNAROUND_EN defined:
  - After every read, HOLD goes to TURN for one cycle with ram_data_oe_o = 0 and req_ready_o = 0, then to IDLE.
  - This guarantees a bus-release gap before a following write drives the pins.
- Undefined:
  - The TURN state and its logic are absent; HOLD always goes to IDLE.

## Structure
- Package ext_ram_pkg holds:
  - the state enum
  - the WAIT_W = 4 localparam
  - maximum-width limits for ADDR_W and DATA_W, used by elaboration-time parameter range checks.
- One sub-module, ext_ram_wait_ctr: a loadable down-counter with load, enable and zero flag, sized WAIT_W.

## Test plan
Parameters for all scenarios: ADDR_W=5, DATA_W=32, WAIT_CYCLES=1.
- Write addr 5'h03, data 32'hDEADBEEF:
  - ram_rw_en_o is high for exactly 2 cycles.
  - ram_data_oe_o is high for 4 cycles.
  - rsp_valid_o pulses 4 cycles after acceptance.
- Read addr 5'h03 with the model returning 32'hDEADBEEF → rsp_rdata_o = 32'hDEADBEEF when rsp_valid_o is high; ram_data_oe_o stays 0 throughout.
- Write immediately followed by read, req_valid_i held high:
  - The second request is accepted exactly one IDLE cycle after HOLD.
  - With EXT_RAM_TURNAROUND_EN, a read→write pair shows one extra cycle with oe low.
- WAIT_CYCLES=0 and WAIT_CYCLES=15: strobe width is 1 and 16 cycles; latency is 3 and 18 cycles.
- reset_i pulsed during ACCESS of a write:
  - ram_rw_en_o and ram_data_oe_o drop asynchronously.
  - No rsp_valid_o is issued.
  - req_ready_o = 1 after release.
- Address 5'h1F and data 32'hFFFFFFFF: the full-width values reach the pins unmodified, with no truncation or wrap.
